conv_out_drain: RTL and testbench

- Reads the conv engine's finished results back out of the two output SRAMs (SRAM_O0 and SRAM_O1, 16-bit words).
- Streams them over a valid/ready interface toward the host or pattern side.
- It is the reader for the write interface that conv uses (we_O*/addr_O*/din_O*).
- Sits beside conv and shares the SRAM_O ports through the top-level mux. It is started once conv raises final_flag.

---
 rtl/conv_pkg.sv | 16 +
 rtl/conv_out_drain_skid_fifo.sv | 56 +++++
 rtl/conv_out_drain.sv | 164 ++++++++++++++++
 tb/tb_conv_out_drain.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants and types for the conv output-drain path.
package conv_pkg;

   localparam int DATA_W        = 16;
   localparam int ADDR_W        = 13;
   localparam int WORDS_DEFAULT = 6272;
   localparam int CNT_W         = 14;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FLUSH,
      DONE
   } drain_state_e;

endpackage

// File: rtl/conv_out_drain_skid_fifo.sv
// Two-entry FIFO that absorbs SRAM read data while the downstream side stalls.
module drain_skid_fifo
   import conv_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_push,
   input  logic              i_pop,
   input  logic [DATA_W-1:0] i_data,
   output logic [DATA_W-1:0] o_head,
   output logic              o_full,
   output logic              o_empty,
   output logic [1:0]        o_count
);

   logic [DATA_W-1:0] r_mem [2];
   logic              r_wrPtr;
   logic              r_rdPtr;
   logic [1:0]        r_count;
   logic              w_doPush;
   logic              w_doPop;

   assign o_full   = (r_count == 2'd2);
   assign o_empty  = (r_count == 2'd0);
   assign o_count  = r_count;
   assign o_head   = r_mem[r_rdPtr];

   // A push into a full FIFO is only taken when the head leaves in the same cycle.
   assign w_doPush = i_push && (!o_full || i_pop);
   assign w_doPop  = i_pop && !o_empty;

   // Storage, pointers and occupancy; the freed head slot can be refilled on the same edge.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wrPtr  <= 1'b0;
         r_rdPtr  <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_doPush) begin
            r_mem[r_wrPtr] <= i_data;
            r_wrPtr        <= ~r_wrPtr;
         end
         if (w_doPop) begin
            r_rdPtr <= ~r_rdPtr;
         end
         case ({w_doPush, w_doPop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/conv_out_drain.sv
// Drains both conv output SRAM banks, bank 0 then bank 1, onto a valid/ready stream.
module conv_out_drain
   import conv_pkg::*;
#(
   parameter int WORDS = WORDS_DEFAULT
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              we_O0,
   output logic              we_O1,
   output logic [ADDR_W-1:0] addr_O0,
   output logic [ADDR_W-1:0] addr_O1,
   input  logic [DATA_W-1:0] dout_O0,
   input  logic [DATA_W-1:0] dout_O1,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              busy,
   output logic              done
);

   localparam logic [CNT_W-1:0] WORDS_CNT = CNT_W'(WORDS);
   localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(2 * WORDS - 1);

   drain_state_e      r_state;
   drain_state_e      w_nextState;
   logic [CNT_W-1:0]  r_rdCnt;
   logic              r_inflight;
   logic              r_inflightSel;
   logic              r_lastBank;
   logic [ADDR_W-1:0] r_lastAddr;

   logic              w_pop;
   logic              w_issue;
   logic              w_bank;
   logic [ADDR_W-1:0] w_rdAddr;
   logic [ADDR_W-1:0] w_activeAddr;
   logic              w_drained;
   logic [DATA_W-1:0] w_pushData;
   logic [DATA_W-1:0] w_head;
   logic              w_full;
   logic              w_empty;
   logic [1:0]        w_count;

   // The drain only ever reads the output SRAMs.
   assign we_O0      = 1'b0;
   assign we_O1      = 1'b0;

   assign w_pop      = out_valid && out_ready;
   assign w_bank     = (r_rdCnt >= WORDS_CNT);
   assign w_rdAddr   = w_bank ? ADDR_W'(r_rdCnt - WORDS_CNT) : ADDR_W'(r_rdCnt);

   // Issue only while the FIFO is guaranteed a slot for the word now leaving the SRAM.
   assign w_issue    = (r_state == RUN) &&
                       (({1'b0, w_count} + {2'b0, r_inflight}) < (3'd2 + {2'b0, w_pop}));

   // Counting the word being popped right now lets DONE follow the last handshake directly.
   assign w_drained  = !r_inflight && (w_empty || (w_count == 2'd1 && w_pop));

   assign w_pushData = r_inflightSel ? dout_O1 : dout_O0;
   assign out_valid  = !w_empty;
   assign out_data   = w_head;

   drain_skid_fifo u_fifo (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_push  (r_inflight),
      .i_pop   (w_pop),
      .i_data  (w_pushData),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   // State register for the IDLE -> RUN -> FLUSH -> DONE sequence.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Read counter plus the bank tag that travels with each read until its data returns.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdCnt       <= '0;
         r_inflight    <= 1'b0;
         r_inflightSel <= 1'b0;
         r_lastBank    <= 1'b0;
         r_lastAddr    <= '0;
      end else begin
         r_inflight    <= w_issue;
         r_inflightSel <= w_bank;
         if (r_state == IDLE && start) begin
            r_rdCnt    <= '0;
            r_lastBank <= 1'b0;
            r_lastAddr <= '0;
         end else if (w_issue) begin
            r_rdCnt    <= r_rdCnt + CNT_W'(1);
            r_lastBank <= w_bank;
            r_lastAddr <= w_rdAddr;
         end
      end
   end

   // Next state, status flags and SRAM addresses; the bank not being read always sees address 0.
   always_comb begin
      w_nextState  = r_state;
      addr_O0      = '0;
      addr_O1      = '0;
      busy         = 1'b0;
      done         = 1'b0;
      w_activeAddr = '0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_nextState = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (w_issue) begin
               w_activeAddr = w_rdAddr;
            end else if (r_lastBank == w_bank) begin
               w_activeAddr = r_lastAddr;
            end
            if (w_bank) begin
               addr_O1 = w_activeAddr;
            end else begin
               addr_O0 = w_activeAddr;
            end
            if (w_issue && r_rdCnt == LAST_CNT) begin
               w_nextState = FLUSH;
            end
         end
         FLUSH: begin
            busy = 1'b1;
            if (r_lastBank) begin
               addr_O1 = r_lastAddr;
            end else begin
               addr_O0 = r_lastAddr;
            end
            if (w_drained) begin
               w_nextState = DONE;
            end
         end
         DONE: begin
            done        = 1'b1;
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // A word returning from the SRAM must never find the FIFO full without a pop.
   assert property (@(posedge clk) disable iff (!rst_n) !(r_inflight && w_full && !w_pop));

endmodule

// File: tb/tb_conv_out_drain.sv
// Scoreboard bench for conv_out_drain: SRAM model, random back-pressure, reset and restart cases.
module tb_conv_out_drain;

   localparam int WORDS = 6272;
   localparam int TOTAL = 2 * WORDS;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        out_ready = 1'b0;
   logic        we_O0;
   logic        we_O1;
   logic [12:0] addr_O0;
   logic [12:0] addr_O1;
   logic [15:0] dout_O0 = '0;
   logic [15:0] dout_O1 = '0;
   logic        out_valid;
   logic [15:0] out_data;
   logic        busy;
   logic        done;

   int          cyc = 0;
   int          vectors = 0;
   int          miscompares = 0;
   int          accepted = 0;
   int          doneCount = 0;
   int          startCyc = 0;
   logic [15:0] expQ[$];
   logic [15:0] mem0[WORDS];
   logic [15:0] mem1[WORDS];
   bit          prevStall = 1'b0;
   logic [15:0] prevData = '0;

   conv_out_drain #(.WORDS(WORDS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .we_O0     (we_O0),
      .we_O1     (we_O1),
      .addr_O0   (addr_O0),
      .addr_O1   (addr_O1),
      .dout_O0   (dout_O0),
      .dout_O1   (dout_O1),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy),
      .done      (done)
   );

   // Free-running clock and cycle counter.
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous-read SRAM banks: data appears one cycle after the address.
   always @(posedge clk) begin
      dout_O0 <= mem0[addr_O0];
      dout_O1 <= mem1[addr_O1];
   end

   // Expected word k of a complete drain: all of bank 0 in order, then all of bank 1.
   function automatic logic [15:0] expWord(input int k);
      return (k < WORDS) ? mem0[k] : mem1[k - WORDS];
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at cycle %0d", name, actual, expected, cyc);
      end
   endtask

   // Load the scoreboard with a full drain and raise start for one cycle.
   task automatic applyStimulus();
      expQ.delete();
      for (int k = 0; k < TOTAL; k++) expQ.push_back(expWord(k));
      start    = 1'b1;
      startCyc = cyc;
   endtask

   // Monitor: pops the scoreboard on every handshake and checks per-cycle invariants.
   always @(negedge clk) begin
      if (!rst_n) begin
         prevStall = 1'b0;
      end else begin
         checkOutput("we_O0", {31'b0, we_O0}, 32'd0);
         checkOutput("we_O1", {31'b0, we_O1}, 32'd0);
         checkOutput("inactive_addr_zero", {31'b0, (addr_O0 == 13'd0 || addr_O1 == 13'd0)}, 32'd1);
         checkOutput("fifo_count_le_2", {31'b0, (dut.w_count <= 2'd2)}, 32'd1);
         if (prevStall) begin
            checkOutput("stall_valid_hold", {31'b0, out_valid}, 32'd1);
            checkOutput("stall_data_hold", {16'b0, out_data}, {16'b0, prevData});
         end
         if (out_valid && out_ready) begin
            if (expQ.size() == 0) begin
               vectors++;
               miscompares++;
               $display("[TB] FAIL extra_word: actual=0x%0h required=none at cycle %0d", out_data, cyc);
            end else begin
               checkOutput("stream_word", {16'b0, out_data}, {16'b0, expQ.pop_front()});
            end
            accepted++;
         end
         prevStall = out_valid && !out_ready;
         prevData  = out_data;
         if (done) doneCount++;
      end
   end

   initial begin
      int base;
      int dsnap;
      int firstV;
      int doneC;
      bit pulsed;
      bit held;
      int n;

      for (int i = 0; i < WORDS; i++) begin
         mem0[i] = 16'(i);
         mem1[i] = 16'h8000 | 16'(i);
      end

      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("reset_out_data", {16'b0, out_data}, 32'd0);
      checkOutput("reset_addr_O0", {19'b0, addr_O0}, 32'd0);
      checkOutput("reset_addr_O1", {19'b0, addr_O1}, 32'd0);
      checkOutput("reset_busy", {31'b0, busy}, 32'd0);
      checkOutput("reset_done", {31'b0, done}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Drain A: reset arrives after 3000 words.
      base      = accepted;
      dsnap     = doneCount;
      out_ready = 1'b1;
      applyStimulus();
      n = 0;
      do begin
         @(posedge clk); #1;
         start = 1'b0;
         n++;
      end while (accepted - base < 3000 && n < 10000);
      checkOutput("drainA_reach_3000", {31'b0, (accepted - base >= 3000)}, 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("midreset_out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("midreset_out_data", {16'b0, out_data}, 32'd0);
      checkOutput("midreset_addr_O0", {19'b0, addr_O0}, 32'd0);
      checkOutput("midreset_addr_O1", {19'b0, addr_O1}, 32'd0);
      checkOutput("midreset_busy", {31'b0, busy}, 32'd0);
      expQ.delete();
      for (int r = 0; r < 4; r++) begin
         @(negedge clk);
         checkOutput("midreset_done", {31'b0, done}, 32'd0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("drainA_no_done", doneCount - dsnap, 32'd0);

      // Drain B: full-rate, replay from O0[0], stray start while busy at word 100.
      base      = accepted;
      dsnap     = doneCount;
      firstV    = -1;
      doneC     = -1;
      pulsed    = 1'b0;
      out_ready = 1'b1;
      applyStimulus();
      n = 0;
      while (doneC < 0 && n < 20000) begin
         @(negedge clk);
         if (firstV < 0 && out_valid) firstV = cyc;
         if (done) doneC = cyc;
         @(posedge clk); #1;
         start = 1'b0;
         if (!pulsed && accepted - base == 100) begin
            start  = 1'b1;
            pulsed = 1'b1;
         end
         n++;
      end
      start = 1'b0;
      repeat (6) @(negedge clk);
      checkOutput("drainB_first_valid_latency", firstV - startCyc, 32'd3);
      checkOutput("drainB_done_cycle", doneC - startCyc, 32'd12547);
      checkOutput("drainB_word_count", accepted - base, TOTAL);
      checkOutput("drainB_done_pulses", doneCount - dsnap, 32'd1);
      checkOutput("drainB_queue_empty", expQ.size(), 32'd0);
      checkOutput("drainB_idle_busy", {31'b0, busy}, 32'd0);

      // Drain C: 30% random ready, 50-cycle stall on the last bank-0 word.
      @(posedge clk); #1;
      base      = accepted;
      dsnap     = doneCount;
      doneC     = -1;
      held      = 1'b0;
      out_ready = ($urandom_range(0, 9) < 3);
      applyStimulus();
      n = 0;
      while (doneC < 0 && n < 80000) begin
         @(negedge clk);
         if (done) doneC = cyc;
         @(posedge clk); #1;
         start = 1'b0;
         if (!held && accepted - base == WORDS - 1) begin
            held      = 1'b1;
            out_ready = 1'b0;
            for (int h = 0; h < 50; h++) begin
               @(negedge clk);
               if (h >= 5) begin
                  checkOutput("boundary_hold_valid", {31'b0, out_valid}, 32'd1);
                  checkOutput("boundary_hold_data", {16'b0, out_data}, {16'b0, expWord(WORDS - 1)});
               end
               @(posedge clk); #1;
            end
            out_ready = 1'b1;
            @(negedge clk);
            checkOutput("boundary_release_data", {16'b0, out_data}, {16'b0, expWord(WORDS - 1)});
            @(posedge clk); #1;
            @(negedge clk);
            checkOutput("boundary_next_valid", {31'b0, out_valid}, 32'd1);
            checkOutput("boundary_next_data", {16'b0, out_data}, {16'b0, expWord(WORDS)});
            @(posedge clk); #1;
         end
         out_ready = ($urandom_range(0, 9) < 3);
         n++;
      end
      out_ready = 1'b1;
      repeat (6) @(negedge clk);
      checkOutput("drainC_done_seen", {31'b0, (doneC >= 0)}, 32'd1);
      checkOutput("drainC_boundary_hit", {31'b0, held}, 32'd1);
      checkOutput("drainC_word_count", accepted - base, TOTAL);
      checkOutput("drainC_done_pulses", doneCount - dsnap, 32'd1);
      checkOutput("drainC_queue_empty", expQ.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
